// File: rtl/medidor_frequencia.sv
// Frequency/period meter: counts rising edges of sinal_in per gate window and
// measures the clk_alta_f period between consecutive rising edges.
module medidor_frequencia #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_alta_f,
  input  logic             rst_n,
  input  logic             habilita,
  input  logic             sinal_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic [CNT_W-1:0] periodo,
  output logic             periodo_valid,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE,
    CONTA
  } estado_t;

  estado_t          estado;
  logic             s1, s2, s3;
  logic             sobe;
  logic [CNT_W-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             tem_anterior;

  logic [CNT_W-1:0] edge_soma;
  logic             edge_hit;
  logic [CNT_W-1:0] per_prox;
  logic             per_hit;

  // Saturating next values; a counter reaching all-ones raises the sticky ovf.
  always_comb begin
    sobe      = s2 & ~s3;
    edge_soma = edge_cnt;
    per_prox  = per_cnt;
    if (sobe && (edge_cnt != CNT_MAX)) begin
      edge_soma = edge_cnt + CNT_ONE;
    end
    if (per_cnt != CNT_MAX) begin
      per_prox = per_cnt + CNT_ONE;
    end
    edge_hit = sobe && (edge_soma == CNT_MAX);
    per_hit  = (per_prox == CNT_MAX);
  end

  always_ff @(posedge clk_alta_f or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      per_cnt       <= '0;
      tem_anterior  <= 1'b0;
      freq          <= '0;
      freq_valid    <= 1'b0;
      periodo       <= '0;
      periodo_valid <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      s1            <= sinal_in;
      s2            <= s1;
      s3            <= s2;
      freq_valid    <= 1'b0;
      periodo_valid <= 1'b0;

      case (estado)
        IDLE: begin
          gate_cnt     <= '0;
          edge_cnt     <= '0;
          per_cnt      <= '0;
          tem_anterior <= 1'b0;
          if (habilita) begin
            estado <= CONTA;
            ovf    <= 1'b0;
          end
        end

        CONTA: begin
          // Dropping habilita discards the partial window without publishing.
          if (!habilita) begin
            estado       <= IDLE;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            per_cnt      <= '0;
            tem_anterior <= 1'b0;
          end else begin
            if (edge_hit) begin
              ovf <= 1'b1;
            end
            if (gate_cnt == GATE_LAST) begin
              freq       <= edge_soma;
              freq_valid <= 1'b1;
              gate_cnt   <= '0;
              edge_cnt   <= '0;
            end else begin
              gate_cnt <= gate_cnt + CNT_ONE;
              edge_cnt <= edge_soma;
            end

            // The first edge after enabling only arms the period measurement.
            if (sobe) begin
              tem_anterior <= 1'b1;
              per_cnt      <= CNT_ONE;
              if (tem_anterior) begin
                periodo       <= per_cnt;
                periodo_valid <= 1'b1;
              end
            end else if (tem_anterior) begin
              per_cnt <= per_prox;
              if (per_hit) begin
                ovf <= 1'b1;
              end
            end
          end
        end

        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_frequencia.sv
// Self-checking bench for medidor_frequencia: timestamp-based reference model,
// directed segment table, hand-written corner sequences and random stimulus.
module tb_medidor_frequencia;

  localparam int GATE = 100;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk_alta_f = 1'b0;
  logic         rst_n;
  logic         habilita;
  logic         sinal_in;
  logic [W-1:0] freq;
  logic         freq_valid;
  logic [W-1:0] periodo;
  logic         periodo_valid;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int fvSeen;
  int pvSeen;
  int now      = 0;
  int wavePhase;
  logic habR;

  // Reference model: input history plus edge timestamps rather than counters.
  bit sampQ[$];
  bit mActive;
  int mWinStart;
  int mEdges;
  int mLastEdge;
  int mFreq;
  int mPer;
  bit mFv;
  bit mPv;
  bit mOvf;

  typedef struct {
    logic hab;
    int   halfPer;
    logic level;
    int   cycles;
    int   expFreq;
    int   expPer;
    logic expOvf;
    int   expFv;
    int   expPv;
  } vec_t;

  vec_t vecs[8];

  always #5 clk_alta_f = ~clk_alta_f;

  medidor_frequencia #(
    .GATE_CYCLES(GATE),
    .CNT_W      (W)
  ) dut (
    .clk_alta_f   (clk_alta_f),
    .rst_n        (rst_n),
    .habilita     (habilita),
    .sinal_in     (sinal_in),
    .freq         (freq),
    .freq_valid   (freq_valid),
    .periodo      (periodo),
    .periodo_valid(periodo_valid),
    .ovf          (ovf)
  );

  function automatic void modelReset();
    sampQ.delete();
    for (int i = 0; i < 3; i++) sampQ.push_back(1'b0);
    mActive   = 1'b0;
    mWinStart = 0;
    mEdges    = 0;
    mLastEdge = -1;
    mFreq     = 0;
    mPer      = 0;
    mFv       = 1'b0;
    mPv       = 1'b0;
    mOvf      = 1'b0;
  endfunction

  function automatic void modelStep(bit hab, bit sin);
    int n;
    bit sobe;
    sampQ.push_back(sin);
    if (sampQ.size() > 4) void'(sampQ.pop_front());
    sobe = sampQ[1] && !sampQ[0];
    mFv  = 1'b0;
    mPv  = 1'b0;
    if (!mActive) begin
      if (hab) begin
        mActive   = 1'b1;
        mWinStart = now + 1;
        mEdges    = 0;
        mLastEdge = -1;
        mOvf      = 1'b0;
      end
    end else if (!hab) begin
      mActive = 1'b0;
    end else begin
      n = mEdges + (sobe ? 1 : 0);
      if (n >= MAXV) begin
        n    = MAXV;
        mOvf = 1'b1;
      end
      if (now - mWinStart == GATE - 1) begin
        mFreq     = n;
        mFv       = 1'b1;
        mWinStart = now + 1;
        mEdges    = 0;
      end else begin
        mEdges = n;
      end
      if (sobe) begin
        if (mLastEdge >= 0) begin
          mPer = (now - mLastEdge > MAXV) ? MAXV : now - mLastEdge;
          mPv  = 1'b1;
        end
        mLastEdge = now;
      end else if (mLastEdge >= 0 && now - mLastEdge + 1 >= MAXV) begin
        mOvf = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput();
    checks++;
    if (freq !== W'(mFreq) || freq_valid !== mFv || periodo !== W'(mPer) ||
        periodo_valid !== mPv || ovf !== mOvf) begin
      failures++;
      $display("[TB] FAIL outputs at edge %0d: got freq=%0d fv=%0b per=%0d pv=%0b ovf=%0b, expected freq=%0d fv=%0b per=%0d pv=%0b ovf=%0b",
               now, freq, freq_valid, periodo, periodo_valid, ovf, mFreq, mFv, mPer, mPv, mOvf);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hab, input logic sin);
    rst_n    = rst;
    habilita = hab;
    sinal_in = sin;
    @(posedge clk_alta_f);
    now++;
    if (!rst) modelReset();
    else modelStep(hab, sin);
    #1;
    checkOutput();
    if (freq_valid === 1'b1) fvSeen++;
    if (periodo_valid === 1'b1) pvSeen++;
  endtask

  function automatic logic squareWave(int halfPer);
    return ((wavePhase % (2 * halfPer)) < halfPer);
  endfunction

  initial begin
    rst_n    = 1'b0;
    habilita = 1'b0;
    sinal_in = 1'b0;
    habR     = 1'b1;
    modelReset();

    //            hab  half lvl cyc  freq per  ovf  fv pv
    vecs[0] = '{1'b0, 0, 1'b0,  20,   0,   0, 1'b0, 0,  0};
    vecs[1] = '{1'b1, 5, 1'b0, 300,  10,  10, 1'b0, 2, 29};
    vecs[2] = '{1'b1, 0, 1'b1, 250,   0,  10, 1'b0, 3,  1};
    vecs[3] = '{1'b1, 0, 1'b1, 100,   0,  10, 1'b1, 1,  0};
    vecs[4] = '{1'b1, 0, 1'b0,   5,   0,  10, 1'b1, 0,  0};
    vecs[5] = '{1'b1, 0, 1'b1,  20,   0, 255, 1'b1, 0,  1};
    vecs[6] = '{1'b0, 0, 1'b1,  10,   0, 255, 1'b1, 0,  0};
    vecs[7] = '{1'b1, 5, 1'b0,  30,   0,  10, 1'b0, 0,  1};

    // Reset held with a toggling input: everything must read zero.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'(i % 2));
    checkValue("reset freq", int'(freq), 0);
    checkValue("reset periodo", int'(periodo), 0);
    checkValue("reset ovf", int'(ovf), 0);

    for (int v = 0; v < 8; v++) begin
      fvSeen = 0;
      pvSeen = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        wavePhase = c;
        applyStimulus(1'b1, vecs[v].hab,
                      (vecs[v].halfPer == 0) ? vecs[v].level : squareWave(vecs[v].halfPer));
      end
      checkValue($sformatf("vec%0d freq", v), int'(freq), vecs[v].expFreq);
      checkValue($sformatf("vec%0d periodo", v), int'(periodo), vecs[v].expPer);
      checkValue($sformatf("vec%0d ovf", v), int'(ovf), int'(vecs[v].expOvf));
      checkValue($sformatf("vec%0d freq_valid count", v), fvSeen, vecs[v].expFv);
      checkValue($sformatf("vec%0d periodo_valid count", v), pvSeen, vecs[v].expPv);
    end

    // Edge landing on the last gate cycle belongs to the closing window.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 250; r++) begin
      applyStimulus(1'b1, 1'b1, 1'((r >= 8 && r < 13) || (r >= 48 && r < 53) ||
                                  (r >= 98 && r < 103) || (r >= 148 && r < 153)));
      if (r == 100) begin
        checkValue("aligned edge freq", int'(freq), 3);
        checkValue("aligned edge freq_valid", int'(freq_valid), 1);
        checkValue("aligned edge periodo", int'(periodo), 50);
      end
      if (r == 200) checkValue("window after aligned edge freq", int'(freq), 1);
    end

    // Partial window discarded when habilita drops mid-window.
    fvSeen = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkValue("partial window freq_valid count", fvSeen, 0);
    checkValue("partial window freq held", int'(freq), 1);
    fvSeen = 0;
    pvSeen = 0;
    for (int c = 0; c < 110; c++) begin
      wavePhase = c;
      applyStimulus(1'b1, 1'b1, squareWave(5));
    end
    checkValue("re-enable freq_valid count", fvSeen, 1);
    checkValue("re-enable freq", int'(freq), 10);
    checkValue("re-enable periodo_valid count", pvSeen, 10);
    checkValue("re-enable ovf", int'(ovf), 0);

    // Asynchronous reset in the middle of a window.
    for (int c = 110; c < 150; c++) begin
      wavePhase = c;
      applyStimulus(1'b1, 1'b1, squareWave(5));
    end
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    checkValue("async reset freq", int'(freq), 0);
    checkValue("async reset periodo", int'(periodo), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    fvSeen = 0;
    for (int c = 0; c < 90; c++) begin
      wavePhase = c;
      applyStimulus(1'b1, 1'b1, squareWave(5));
    end
    checkValue("post-reset freq_valid count", fvSeen, 0);

    // Random runs of levels with occasional long holds and habilita flips.
    for (int i = 0; i < 3000;) begin
      int   runLen;
      logic lvl;
      runLen = ($urandom_range(0, 30) == 0) ? int'($urandom_range(200, 320))
                                             : int'($urandom_range(1, 12));
      lvl = 1'($urandom_range(0, 1));
      for (int j = 0; j < runLen; j++) begin
        if ($urandom_range(0, 199) == 0) habR = ~habR;
        applyStimulus(1'b1, habR, lvl);
      end
      i += runLen;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/medidor_frequencia.md
Name: medidor_frequencia

Overview:
- Frequency/period meter: the receive-side counterpart of the 50 MHz → 1 Hz divider.
- The divider derives a slow signal from clk_alta_f. This block takes an external slow signal, sinal_in, sampled on clk_alta_f, and reports two measurements:
  - edges per gate window (Hz when gate = 1 s);
  - period in clk_alta_f cycles.
- Feeds the display/debug path; also checks divider outputs on the board.

Parameters:
- GATE_CYCLES, 50000000, clk_alta_f cycles per measurement window (1 s at 50 MHz).
- CNT_W, 27, width of all counters and results; must satisfy 2^CNT_W > GATE_CYCLES.

Ports:
- clk_alta_f  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous reset, active low
- habilita  input  1  measurement enable; level sensitive
- sinal_in  input  1  asynchronous signal under measurement
- freq  output  CNT_W  rising edges counted in last complete window
- freq_valid  output  1  one-cycle pulse when freq updates
- periodo  output  CNT_W  clk_alta_f cycles between last two rising edges
- periodo_valid  output  1  one-cycle pulse when periodo updates
- ovf  output  1  sticky saturation flag (edge or period counter hit all-ones)

Behaviour:
- Reset: rst_n low asynchronously clears all registers.
  - Outputs are 0: freq, periodo, freq_valid, periodo_valid, ovf.
  - State is IDLE, synchronizer is 0, tem_anterior is 0.
- Synchronizer and edge detect:
  - s1 <= sinal_in; s2 <= s1; s3 <= s2.
  - sobe = s2 & ~s3.
  - An input rising edge produces sobe 2-3 cycles later. Pulses shorter than one clock may be missed; this is allowed.
- States:
  - IDLE: counters held at 0, tem_anterior = 0, valids 0, freq/periodo hold last values.
    - habilita = 1 → CONTA next cycle; gate_cnt = 0.
  - CONTA: gate_cnt increments each cycle; edge_cnt += sobe, saturating at 2^CNT_W-1 (sets ovf).
    - On cycle with gate_cnt == GATE_CYCLES-1:
      - freq <= edge_cnt + sobe (saturating);
      - freq_valid = 1 next cycle for exactly one cycle;
      - gate_cnt <= 0; edge_cnt <= 0; stay in CONTA (back-to-back windows, no dead cycle).
    - habilita = 0 → IDLE next cycle. A partial window is discarded: no freq update, no freq_valid.
- Period path (active only in CONTA):
  - per_cnt increments each cycle, saturating at all-ones (sets ovf).
  - On sobe with tem_anterior = 1:
    - periodo <= per_cnt;
    - periodo_valid pulses one cycle;
    - per_cnt <= 1.
  - On sobe with tem_anterior = 0: tem_anterior <= 1; per_cnt <= 1; no publish.
  - If saturated when sobe arrives, periodo <= all-ones.
- Simultaneous events:
  - Gate end and sobe in the same cycle: the edge counts in the closing window; the new window starts at 0.
  - freq_valid and periodo_valid may assert in the same cycle.
- ovf clears only on reset or when leaving IDLE (habilita rising).
- Latency:
  - freq_valid asserts 1 cycle after the last gate cycle.
  - periodo_valid asserts 1 cycle after sobe.
- Reset mid-window: immediate clear, no partial output.

Test Plan:
- Reset: hold rst_n = 0 with toggling sinal_in → all outputs 0. Release with habilita = 0 → outputs stay 0, no valids.
- GATE_CYCLES = 100; square wave period 10 clk; habilita = 1 → each window freq = 10 with one freq_valid per 100 cycles; periodo = 10 with periodo_valid every 10 cycles; first edge publishes no period.
- Constant sinal_in = 1 → freq = 0 every window, no periodo_valid. Then one edge plus a long wait with CNT_W = 8 → ovf = 1; periodo = 255 on next edge.
- Edge aligned to the last gate cycle → counted in the closing window (freq = N). Next window starts from 0; total over two windows equals edges applied.
- habilita dropped at cycle 50 of a window → no freq_valid, freq keeps previous value. Re-enable → new full window, ovf cleared, first edge again unpublished.
- rst_n pulsed low mid-window while valids pending → outputs 0 immediately, no valid pulse after release until a full window completes.
